mult_div_seq: RTL

- Sequential 32-bit signed multiply/divide unit that sits directly downstream of the team's add_sub block in the ALU datapath.
- Performs one add/subtract step per clock through a single add_sub instance:
  - radix-2 Booth for multiply;
  - restoring division on magnitudes for divide.
- Fixed 32-iteration latency, start-pulse / ready-pulse handshake.
- Results and exception go to the execute stage alongside the combinational ALU result.

---
 rtl/mult_div_pkg.sv | 35 +++
 rtl/add_sub.sv | 33 +++
 rtl/mult_div_seq.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared encodings and helpers for the sequential multiply/divide unit.
// The negate/magnitude helpers let the divider avoid a second adder instance.
package mult_div_pkg;

    localparam int WIDTH      = 32;
    localparam int ITERATIONS = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } op_t;

    // Two's complement negation by invert-plus-one.
    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
        return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
    endfunction

    // Unsigned magnitude of a signed value; the most negative value maps to itself.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] m;
        if (v[WIDTH-1]) begin
            m = negate(v);
        end else begin
            m = v;
        end
        return m;
    endfunction

endpackage

// File: rtl/add_sub.sv
// Shared 32-bit adder/subtractor of the ALU datapath.
// sub=1 computes a - b as a + ~b + 1; cout is then the no-borrow flag.
module add_sub
    import mult_div_pkg::*;
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff_s;
    logic [WIDTH:0]   full_s;

    // Conditional inversion of b and the carry-propagating addition.
    always_comb begin
        b_eff_s = {WIDTH{1'b0}};
        full_s  = {(WIDTH+1){1'b0}};
        if (sub) begin
            b_eff_s = ~b;
        end else begin
            b_eff_s = b;
        end
        full_s = {1'b0, a} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub};
    end

    assign sum      = full_s[WIDTH-1:0];
    assign cout     = full_s[WIDTH];
    assign overflow = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/mult_div_seq.sv
// Sequential 32-bit signed multiply (radix-2 Booth) / divide (restoring) unit
// time-sharing one add_sub; 32 iterations plus one finalise edge per operation.
module mult_div_seq
    import mult_div_pkg::*;
#(
    parameter int WIDTH = mult_div_pkg::WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             ctrl_mult,
    input  logic             ctrl_div,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             result_rdy,
    output logic             busy
);

    state_t           state_r;
    op_t              op_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] acc_r;      // P_hi for multiply, partial remainder for divide
    logic [WIDTH-1:0] lo_r;       // P_lo for multiply, dividend/quotient for divide
    logic             qm1_r;
    logic [WIDTH-1:0] opd_r;      // multiplicand, or divisor magnitude
    logic             neg_r;
    logic             dz_r;
    logic [WIDTH-1:0] result_r;
    logic             exception_r;
    logic             rdy_r;
    logic             busy_r;

    logic [WIDTH-1:0] as_a_s;
    logic             as_sub_s;
    logic [WIDTH-1:0] as_sum_s;
    logic             as_cout_s;
    logic             as_ovf_s;

    logic [1:0]       booth_s;
    logic [WIDTH-1:0] rem_shift_s;
    logic [WIDTH-1:0] hi_sum_s;
    logic             hi_top_s;
    logic [WIDTH-1:0] acc_next_s;
    logic [WIDTH-1:0] lo_next_s;
    logic [WIDTH-1:0] fin_result_s;
    logic             fin_exc_s;
    logic             start_s;

    add_sub u_add_sub (
        .a        (as_a_s),
        .b        (opd_r),
        .sub      (as_sub_s),
        .sum      (as_sum_s),
        .cout     (as_cout_s),
        .overflow (as_ovf_s)
    );

    assign start_s = ctrl_mult ^ ctrl_div;

    // Adder operand selection for the current Booth or restoring step.
    always_comb begin
        booth_s     = {lo_r[0], qm1_r};
        rem_shift_s = {acc_r[WIDTH-2:0], lo_r[WIDTH-1]};
        as_a_s      = acc_r;
        as_sub_s    = 1'b0;
        if (op_r == OP_MULT) begin
            as_a_s   = acc_r;
            as_sub_s = (booth_s == 2'b10);
        end else begin
            as_a_s   = rem_shift_s;
            as_sub_s = 1'b1;
        end
    end

    // Next register contents for one iteration.
    // The multiply shift feeds in the true 33-bit sign (sum sign corrected by
    // overflow) so P_hi stays exact even when the multiplicand is INT_MIN.
    always_comb begin
        hi_sum_s   = acc_r;
        hi_top_s   = acc_r[WIDTH-1];
        acc_next_s = acc_r;
        lo_next_s  = lo_r;
        if (op_r == OP_MULT) begin
            case (booth_s)
                2'b01, 2'b10: begin
                    hi_sum_s = as_sum_s;
                    hi_top_s = as_sum_s[WIDTH-1] ^ as_ovf_s;
                end
                default: begin
                    hi_sum_s = acc_r;
                    hi_top_s = acc_r[WIDTH-1];
                end
            endcase
            acc_next_s = {hi_top_s, hi_sum_s[WIDTH-1:1]};
            lo_next_s  = {hi_sum_s[0], lo_r[WIDTH-1:1]};
        end else begin
            if (as_cout_s) begin
                acc_next_s = as_sum_s;
            end else begin
                acc_next_s = rem_shift_s;
            end
            lo_next_s = {lo_r[WIDTH-2:0], as_cout_s};
        end
    end

    // Final result and exception from the completed iteration registers.
    // A positive quotient with the top bit set can only be INT_MIN / -1.
    always_comb begin
        fin_result_s = lo_r;
        fin_exc_s    = 1'b0;
        if (op_r == OP_MULT) begin
            fin_result_s = lo_r;
            fin_exc_s    = (acc_r != {WIDTH{lo_r[WIDTH-1]}});
        end else if (dz_r) begin
            fin_result_s = {WIDTH{1'b0}};
            fin_exc_s    = 1'b1;
        end else if (neg_r) begin
            fin_result_s = negate(lo_r);
            fin_exc_s    = 1'b0;
        end else begin
            fin_result_s = lo_r;
            fin_exc_s    = lo_r[WIDTH-1];
        end
    end

    // Control FSM, iteration datapath and registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            op_r        <= OP_MULT;
            cnt_r       <= {CNT_W{1'b0}};
            acc_r       <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
            qm1_r       <= 1'b0;
            opd_r       <= {WIDTH{1'b0}};
            neg_r       <= 1'b0;
            dz_r        <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            exception_r <= 1'b0;
            rdy_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rdy_r <= 1'b0;
                    if (start_s) begin
                        state_r <= RUN;
                        busy_r  <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                        acc_r   <= {WIDTH{1'b0}};
                        qm1_r   <= 1'b0;
                        if (ctrl_div) begin
                            op_r  <= OP_DIV;
                            lo_r  <= magnitude(operand_a);
                            opd_r <= magnitude(operand_b);
                            neg_r <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                            dz_r  <= (operand_b == {WIDTH{1'b0}});
                        end else begin
                            op_r  <= OP_MULT;
                            lo_r  <= operand_b;
                            opd_r <= operand_a;
                            neg_r <= 1'b0;
                            dz_r  <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    if (cnt_r == CNT_W'(ITERATIONS)) begin
                        state_r     <= DONE;
                        result_r    <= fin_result_s;
                        exception_r <= fin_exc_s;
                        rdy_r       <= 1'b1;
                    end else begin
                        acc_r <= acc_next_s;
                        lo_r  <= lo_next_s;
                        qm1_r <= lo_r[0];
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    rdy_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    rdy_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign result     = result_r;
    assign exception  = exception_r;
    assign result_rdy = rdy_r;
    assign busy       = busy_r;

endmodule
